grayscale_to_rgb: RTL and testbench

GRAYSCALE_TO_RGB -- requirements
Module: grayscale_to_rgb

---
 rtl/grayscale_to_rgb_pkg.sv | 16 +
 rtl/grayscale_to_rgb_colormap.sv | 63 ++++++
 rtl/grayscale_to_rgb.sv | 70 +++++++
 tb/tb_grayscale_to_rgb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/grayscale_to_rgb_pkg.sv
// Shared constants for the grayscale-to-RGB colour mapper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package grayscale_to_rgb_pkg;

    // Colormap selector encodings; any other value falls back to gray replicate.
    localparam int CMAP_GRAY = 0;
    localparam int CMAP_HEAT = 1;

    // Default pixel channel width.
    localparam int DATA_W_DEFAULT = 8;

    // The heat map is split into 2^SEG_W segments, indexed by the top SEG_W bits of g.
    localparam int SEG_W = 2;

endpackage : grayscale_to_rgb_pkg

// File: rtl/grayscale_to_rgb_colormap.sv
// Combinational gray -> RGB mapping (optional invert, then replicate or 4-segment heat map).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: gray_i (pixel in), red_o/green_o/blue_o (mapped channels out).
module gray_colormap
    import grayscale_to_rgb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int COLORMAP = CMAP_GRAY,
    parameter int INVERT   = 0
) (
    input  logic [DATA_W-1:0] gray_i,
    output logic [DATA_W-1:0] red_o,
    output logic [DATA_W-1:0] green_o,
    output logic [DATA_W-1:0] blue_o
);

    localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};

    logic [DATA_W-1:0] g;
    logic [SEG_W-1:0]  seg;
    logic [DATA_W-1:0] ramp_up;
    logic [DATA_W-1:0] ramp_dn;

    assign g   = (INVERT != 0) ? ~gray_i : gray_i;
    assign seg = g[DATA_W-1 -: SEG_W];

    // Offset within a segment scaled by 4: dropping the SEG_W segment bits and
    // appending two zeros keeps the width at DATA_W and can never overflow.
    assign ramp_up = {g[DATA_W-SEG_W-1:0], 2'b00};
    assign ramp_dn = MAX_VAL - ramp_up;

    always_comb begin
        red_o   = g;
        green_o = g;
        blue_o  = g;
        if (COLORMAP == CMAP_HEAT) begin
            case (seg)
                2'd0: begin
                    red_o   = '0;
                    green_o = ramp_up;
                    blue_o  = MAX_VAL;
                end
                2'd1: begin
                    red_o   = '0;
                    green_o = MAX_VAL;
                    blue_o  = ramp_dn;
                end
                2'd2: begin
                    red_o   = ramp_up;
                    green_o = MAX_VAL;
                    blue_o  = '0;
                end
                default: begin
                    red_o   = MAX_VAL;
                    green_o = ramp_dn;
                    blue_o  = '0;
                end
            endcase
        end
    end

endmodule : gray_colormap

// File: rtl/grayscale_to_rgb.sv
// Gray pixel to RGB: combinational colormap followed by a single output register stage.
// Latency: 1 clock from done_i/grayscale_i to done_o/RGB.
// Backpressure: none; every done_i=1 cycle is accepted, RGB holds when done_i=0.
// Ports: clk, rst (async active-low), grayscale_i/done_i in, red_o/green_o/blue_o/done_o out.
module grayscale_to_rgb
    import grayscale_to_rgb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int COLORMAP = CMAP_GRAY,
    parameter int INVERT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] grayscale_i,
    input  logic              done_i,
    output logic [DATA_W-1:0] red_o,
    output logic [DATA_W-1:0] green_o,
    output logic [DATA_W-1:0] blue_o,
    output logic              done_o
);

    logic [DATA_W-1:0] map_r, map_g, map_b;
    logic [DATA_W-1:0] red_d, green_d, blue_d;
    logic [DATA_W-1:0] red_q, green_q, blue_q;
    logic              done_d, done_q;

    gray_colormap #(
        .DATA_W  (DATA_W),
        .COLORMAP(COLORMAP),
        .INVERT  (INVERT)
    ) u_map (
        .gray_i (grayscale_i),
        .red_o  (map_r),
        .green_o(map_g),
        .blue_o (map_b)
    );

    // Colour registers only load on a valid pixel so the last pixel is held.
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        done_d  = done_i;
        if (done_i) begin
            red_d   = map_r;
            green_d = map_g;
            blue_d  = map_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            done_q  <= done_d;
        end
    end

    assign red_o   = red_q;
    assign green_o = green_q;
    assign blue_o  = blue_q;
    assign done_o  = done_q;

endmodule : grayscale_to_rgb

// File: tb/tb_grayscale_to_rgb.sv
// Bench for grayscale_to_rgb: four configurations driven from shared stimulus,
// each compared against a behavioural reference of the mapping rules.
module tb_grayscale_to_rgb;

    localparam int NI = 4;
    // Per-instance configuration: gray, heat, gray+invert, unsupported (acts as gray).
    localparam int CM_CFG [NI] = '{0, 1, 0, 2};
    localparam int INV_CFG[NI] = '{0, 0, 1, 0};

    logic       clk;
    logic       rst;
    logic [7:0] gray;
    logic       done_in;

    logic [7:0] r_o [NI];
    logic [7:0] g_o [NI];
    logic [7:0] b_o [NI];
    logic       d_o [NI];

    int checks;
    int failures;

    // Reference output state per instance.
    int exp_r[NI];
    int exp_g[NI];
    int exp_b[NI];
    int exp_d;

    grayscale_to_rgb #(.DATA_W(8), .COLORMAP(0), .INVERT(0)) u_gray (
        .clk(clk), .rst(rst), .grayscale_i(gray), .done_i(done_in),
        .red_o(r_o[0]), .green_o(g_o[0]), .blue_o(b_o[0]), .done_o(d_o[0]));
    grayscale_to_rgb #(.DATA_W(8), .COLORMAP(1), .INVERT(0)) u_heat (
        .clk(clk), .rst(rst), .grayscale_i(gray), .done_i(done_in),
        .red_o(r_o[1]), .green_o(g_o[1]), .blue_o(b_o[1]), .done_o(d_o[1]));
    grayscale_to_rgb #(.DATA_W(8), .COLORMAP(0), .INVERT(1)) u_inv (
        .clk(clk), .rst(rst), .grayscale_i(gray), .done_i(done_in),
        .red_o(r_o[2]), .green_o(g_o[2]), .blue_o(b_o[2]), .done_o(d_o[2]));
    grayscale_to_rgb #(.DATA_W(8), .COLORMAP(2), .INVERT(0)) u_bad (
        .clk(clk), .rst(rst), .grayscale_i(gray), .done_i(done_in),
        .red_o(r_o[3]), .green_o(g_o[3]), .blue_o(b_o[3]), .done_o(d_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference mapping, straight from the segment table using integer arithmetic.
    function automatic void ref_map(input int cm, input int inv, input int gin,
                                    output int r, output int gg, output int b);
        int v;
        v = (inv != 0) ? 255 - gin : gin;
        if (cm != 1) begin
            r = v; gg = v; b = v;
        end else if (v < 64) begin
            r = 0; gg = 4 * v; b = 255;
        end else if (v < 128) begin
            r = 0; gg = 255; b = 255 - 4 * (v - 64);
        end else if (v < 192) begin
            r = 4 * (v - 128); gg = 255; b = 0;
        end else begin
            r = 255; gg = 255 - 4 * (v - 192); b = 0;
        end
    endfunction

    task automatic chk(input string tag, input int idx, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, ".done"}, i, int'(d_o[i]), exp_d);
            chk({tag, ".red"},  i, int'(r_o[i]), exp_r[i]);
            chk({tag, ".green"},i, int'(g_o[i]), exp_g[i]);
            chk({tag, ".blue"}, i, int'(b_o[i]), exp_b[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_r[i] = 0; exp_g[i] = 0; exp_b[i] = 0;
        end
        exp_d = 0;
    endtask

    // Apply one pixel at the current (post-edge) time, clock it, update the model, check.
    task automatic step(input string tag, input logic v, input logic [7:0] px);
        int r, gg, b;
        done_in = v;
        gray    = px;
        @(posedge clk);
        #1;
        exp_d = int'(v);
        if (v) begin
            for (int i = 0; i < NI; i++) begin
                ref_map(CM_CFG[i], INV_CFG[i], int'(px), r, gg, b);
                exp_r[i] = r; exp_g[i] = gg; exp_b[i] = b;
            end
        end
        check_all(tag);
    endtask

    initial begin
        logic [7:0] bounds[8];
        checks   = 0;
        failures = 0;
        bounds   = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};

        // Reset with done_i low: outputs zero without any clock edge.
        rst     = 1'b0;
        done_in = 1'b0;
        gray    = 8'hA5;
        #2;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        #2;
        rst = 1'b1;
        step("post_reset_idle", 1'b0, 8'h33);

        // Replicate ramp 1..9 back to back.
        for (int k = 1; k <= 9; k++) step("ramp", 1'b1, 8'(k));

        // Deassert: done_o drops, colours hold at the last pixel.
        step("hold", 1'b0, 8'h77);
        step("hold2", 1'b0, 8'h01);

        // Heat map segment boundaries, streamed.
        for (int k = 0; k < 8; k++) step("heat_bound", 1'b1, bounds[k]);

        // Invert case, g=0x10.
        step("invert", 1'b1, 8'h10);

        // done_i 1->0->1 toggle.
        step("toggle_a", 1'b0, 8'h20);
        step("toggle_b", 1'b1, 8'h90);
        step("toggle_c", 1'b0, 8'hC0);
        step("toggle_d", 1'b1, 8'hF0);

        // Randomized traffic.
        for (int k = 0; k < 150; k++)
            step("random", 1'($urandom_range(0, 3) != 0), 8'($urandom));

        // Mid-stream reset between edges: outputs clear immediately.
        step("pre_rst", 1'b1, 8'h5A);
        done_in = 1'b1;
        gray    = 8'hC3;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("midrst_async");
        @(posedge clk);
        #1;
        check_all("midrst_held");
        // Release with done_i low: no stale pixel may appear.
        done_in = 1'b0;
        #2;
        rst = 1'b1;
        step("midrst_release", 1'b0, 8'hC3);
        step("midrst_release2", 1'b0, 8'hC3);
        // First sample after release is taken normally.
        step("first_after_rst", 1'b1, 8'h47);
        step("first_after_rst2", 1'b1, 8'hB9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_grayscale_to_rgb
